// File: rtl/melody_sequencer_if.sv
// rtl/melody_sequencer_if.sv - control pulses and note outputs of the melody sequencer
interface melody_sequencer_if;
    logic        start;
    logic        stop;
    logic        pause_tgl;
    logic [18:0] period;
    logic        tone_en;
    logic        amp_sd;
    logic        busy;
    logic [5:0]  note_idx;
    logic        song_done;

    modport master (
        output start, stop, pause_tgl,
        input  period, tone_en, amp_sd, busy, note_idx, song_done
    );

    modport slave (
        input  start, stop, pause_tgl,
        output period, tone_en, amp_sd, busy, note_idx, song_done
    );
endinterface

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - steps a (pitch, length) melody ROM and presents one tone period per note
module melody_sequencer #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int UNIT_CYC = 25_000_000,
    parameter int GAP_CYC  = 2_000_000,
    parameter int SONG_LEN = 36,
    parameter bit LOOP     = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    melody_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_PAUSE} state_t;

    state_t      state;
    state_t      resume_state;
    logic [31:0] cnt;
    logic [7:0]  rom_q;
    logic [5:0]  note_idx;
    logic [18:0] period;
    logic        tone_en;
    logic        amp_sd;
    logic        busy;
    logic        song_done;

    // Entry layout {pitch[4:0], len[2:0]}; unlisted entries are 8-unit rests.
    function automatic logic [7:0] rom_entry(input logic [5:0] i);
        case (i)
            6'd0:    return {5'd8,  3'd4};
            6'd1:    return {5'd9,  3'd4};
            6'd2:    return {5'd10, 3'd4};
            6'd3:    return {5'd8,  3'd4};
            6'd16:   return {5'd12, 3'd3};
            6'd17:   return {5'd13, 3'd1};
            6'd35:   return {5'd0,  3'd4};
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [18:0] pitch_period(input logic [4:0] p);
        case (p)
            5'd1:    return 19'(CLK_HZ / 262);
            5'd2:    return 19'(CLK_HZ / 294);
            5'd3:    return 19'(CLK_HZ / 330);
            5'd4:    return 19'(CLK_HZ / 349);
            5'd5:    return 19'(CLK_HZ / 392);
            5'd6:    return 19'(CLK_HZ / 440);
            5'd7:    return 19'(CLK_HZ / 494);
            5'd8:    return 19'(CLK_HZ / 523);
            5'd9:    return 19'(CLK_HZ / 587);
            5'd10:   return 19'(CLK_HZ / 659);
            5'd11:   return 19'(CLK_HZ / 698);
            5'd12:   return 19'(CLK_HZ / 784);
            5'd13:   return 19'(CLK_HZ / 880);
            5'd14:   return 19'(CLK_HZ / 988);
            5'd15:   return 19'(CLK_HZ / 1047);
            5'd16:   return 19'(CLK_HZ / 1175);
            5'd17:   return 19'(CLK_HZ / 1319);
            5'd18:   return 19'(CLK_HZ / 1397);
            5'd19:   return 19'(CLK_HZ / 1568);
            5'd20:   return 19'(CLK_HZ / 1760);
            5'd21:   return 19'(CLK_HZ / 1976);
            default: return 19'd0;
        endcase
    endfunction

    logic [3:0]  units;
    logic [31:0] play_last;
    logic [18:0] load_period;
    logic        last_note;

    // PLAY is loaded with its length minus one so LOAD + PLAY + GAP spans exactly len units.
    assign units       = (rom_q[2:0] == 3'd0) ? 4'd8 : {1'b0, rom_q[2:0]};
    assign play_last   = 32'(units) * 32'(UNIT_CYC) - 32'(GAP_CYC) - 32'd2;
    assign load_period = pitch_period(rom_q[7:3]);
    assign last_note   = (note_idx == 6'(SONG_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            resume_state <= S_PLAY;
            cnt          <= 32'd0;
            rom_q        <= 8'd0;
            note_idx     <= 6'd0;
            period       <= 19'd0;
            tone_en      <= 1'b0;
            amp_sd       <= 1'b0;
            busy         <= 1'b0;
            song_done    <= 1'b0;
        end else begin
            song_done <= 1'b0;
            if (bus.stop) begin
                state    <= S_IDLE;
                cnt      <= 32'd0;
                note_idx <= 6'd0;
                period   <= 19'd0;
                tone_en  <= 1'b0;
                amp_sd   <= 1'b0;
                busy     <= 1'b0;
            end else if (bus.pause_tgl && (state == S_PLAY || state == S_GAP)) begin
                resume_state <= state;
                state        <= S_PAUSE;
                tone_en      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            state    <= S_LOAD;
                            amp_sd   <= 1'b1;
                            busy     <= 1'b1;
                            note_idx <= 6'd0;
                            rom_q    <= rom_entry(6'd0);
                        end
                    end
                    S_LOAD: begin
                        period  <= load_period;
                        tone_en <= (load_period != 19'd0);
                        cnt     <= play_last;
                        state   <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (cnt == 32'd0) begin
                            state   <= S_GAP;
                            cnt     <= 32'(GAP_CYC - 1);
                            tone_en <= 1'b0;
                        end else begin
                            cnt <= cnt - 32'd1;
                        end
                    end
                    S_GAP: begin
                        if (cnt != 32'd0) begin
                            cnt <= cnt - 32'd1;
                        end else if (!last_note) begin
                            note_idx <= note_idx + 6'd1;
                            rom_q    <= rom_entry(note_idx + 6'd1);
                            state    <= S_LOAD;
                        end else begin
                            song_done <= 1'b1;
                            note_idx  <= 6'd0;
                            if (LOOP) begin
                                rom_q <= rom_entry(6'd0);
                                state <= S_LOAD;
                            end else begin
                                state  <= S_IDLE;
                                period <= 19'd0;
                                amp_sd <= 1'b0;
                                busy   <= 1'b0;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (bus.pause_tgl) begin
                            state   <= resume_state;
                            tone_en <= (resume_state == S_PLAY) && (period != 19'd0);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.period    = period;
    assign bus.tone_en   = tone_en;
    assign bus.amp_sd    = amp_sd;
    assign bus.busy      = busy;
    assign bus.note_idx  = note_idx;
    assign bus.song_done = song_done;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - scoreboard bench for melody_sequencer against an elapsed-time note model
module tb_melody_sequencer;
    localparam int U = 100;
    localparam int G = 10;

    typedef struct packed {
        logic [18:0] period;
        logic        tone_en;
        logic        amp_sd;
        logic        busy;
        logic [5:0]  note_idx;
        logic        song_done;
    } out_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic ptgl = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc_n = 0;

    always #5 clk = ~clk;

    melody_sequencer_if if0 ();
    melody_sequencer_if if1 ();
    assign if0.start = start;
    assign if0.stop = stop;
    assign if0.pause_tgl = ptgl;
    assign if1.start = start;
    assign if1.stop = stop;
    assign if1.pause_tgl = ptgl;

    // Instance 0 ends on a default-ROM rest entry and stops; instance 1 loops over four notes.
    melody_sequencer #(.CLK_HZ(100_000_000), .UNIT_CYC(U), .GAP_CYC(G), .SONG_LEN(5), .LOOP(1'b0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    melody_sequencer #(.CLK_HZ(100_000_000), .UNIT_CYC(U), .GAP_CYC(G), .SONG_LEN(4), .LOOP(1'b1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    int song_len[2]   = '{5, 4};
    bit loop_m[2]     = '{1'b0, 1'b1};
    int note_pitch[5] = '{8, 9, 10, 8, 0};
    int note_units[5] = '{4, 4, 4, 4, 8};
    int freq[22] = '{0, 262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784, 880, 988,
                     1047, 1175, 1319, 1397, 1568, 1760, 1976};

    function automatic int exp_period(int p);
        return (p >= 1 && p <= 21) ? 100_000_000 / freq[p] : 0;
    endfunction

    // Model state: t counts cycles elapsed since the note's LOAD cycle.
    bit   m_act[2];
    bit   m_paused[2];
    bit   m_done[2];
    int   m_idx[2];
    int   m_t[2];
    int   m_per[2];
    out_t exp_q0[$];
    out_t exp_q1[$];

    always @(posedge clk) begin
        cyc_n++;
        for (int k = 0; k < 2; k++) begin
            out_t e;
            if (!rst_n) begin
                m_act[k] = 0; m_paused[k] = 0; m_done[k] = 0;
                m_idx[k] = 0; m_t[k] = 0; m_per[k] = 0;
            end else begin
                m_done[k] = 0;
                if (!m_act[k]) begin
                    if (start && !stop) begin
                        m_act[k] = 1; m_paused[k] = 0; m_idx[k] = 0; m_t[k] = 0; m_per[k] = 0;
                    end
                end else if (stop) begin
                    m_act[k] = 0; m_idx[k] = 0;
                end else if (ptgl && (m_paused[k] || m_t[k] != 0)) begin
                    m_paused[k] = !m_paused[k];
                end else if (!m_paused[k]) begin
                    m_t[k]++;
                    if (m_t[k] == 1) m_per[k] = exp_period(note_pitch[m_idx[k]]);
                    if (m_t[k] == note_units[m_idx[k]] * U) begin
                        m_t[k] = 0;
                        if (m_idx[k] == song_len[k] - 1) begin
                            m_done[k] = 1;
                            m_idx[k] = 0;
                            if (!loop_m[k]) m_act[k] = 0;
                        end else begin
                            m_idx[k]++;
                        end
                    end
                end
            end
            e.period    = m_act[k] ? 19'(m_per[k]) : 19'd0;
            e.tone_en   = m_act[k] && !m_paused[k] && m_t[k] >= 1 &&
                          m_t[k] <= note_units[m_idx[k]] * U - G - 1 && note_pitch[m_idx[k]] != 0;
            e.amp_sd    = m_act[k];
            e.busy      = m_act[k];
            e.note_idx  = m_act[k] ? 6'(m_idx[k]) : 6'd0;
            e.song_done = m_done[k];
            if (k == 0) exp_q0.push_back(e);
            else exp_q1.push_back(e);
        end
    end

    function automatic out_t got_out(int k);
        out_t g;
        if (k == 0) g = {if0.period, if0.tone_en, if0.amp_sd, if0.busy, if0.note_idx, if0.song_done};
        else g = {if1.period, if1.tone_en, if1.amp_sd, if1.busy, if1.note_idx, if1.song_done};
        return g;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            out_t e;
            out_t g;
            bit   have;
            have = (k == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
            if (have) begin
                e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                g = got_out(k);
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL out%0d cyc=%0d got per=%0d ten=%b amp=%b busy=%b idx=%0d done=%b exp per=%0d ten=%b amp=%b busy=%b idx=%0d done=%b",
                             k, cyc_n, g.period, g.tone_en, g.amp_sd, g.busy, g.note_idx, g.song_done,
                             e.period, e.tone_en, e.amp_sd, e.busy, e.note_idx, e.song_done);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc_n, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic s, input logic p, input logic t);
        start = s; stop = p; ptgl = t;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; ptgl = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst_n = 1'b1;
        cyc(50);
        check("idle_busy", 32'(if0.busy), 32'd0);
        check("idle_period", 32'(if0.period), 32'd0);

        // Full play: LOAD at edge E, checks sampled after E+n.
        pulse(1, 0, 0);
        check("start_amp", 32'(if0.amp_sd), 32'd1);
        cyc(1);
        check("do_period", 32'(if0.period), 32'd191204);
        check("do_tone", 32'(if0.tone_en), 32'd1);
        cyc(400);
        check("re_period", 32'(if0.period), 32'd170357);
        cyc(1204);
        check("rest_period", 32'(if0.period), 32'd0);
        check("rest_tone", 32'(if0.tone_en), 32'd0);
        check("rest_amp", 32'(if0.amp_sd), 32'd1);
        cyc(795);
        check("song_done", 32'(if0.song_done), 32'd1);
        check("end_amp", 32'(if0.amp_sd), 32'd0);
        check("loop_busy", 32'(if1.busy), 32'd1);
        pulse(0, 1, 0);
        cyc(2);

        // Pause 100 cycles into note 0 for 500 cycles.
        pulse(1, 0, 0);
        cyc(99);
        pulse(0, 0, 1);
        cyc(249);
        check("pause_tone", 32'(if0.tone_en), 32'd0);
        check("pause_period", 32'(if0.period), 32'd191204);
        cyc(250);
        pulse(0, 0, 1);
        cyc(950);
        pulse(0, 1, 0);
        cyc(2);

        // Stop in the GAP of note 2, then start and stop together.
        pulse(1, 0, 0);
        cyc(1194);
        pulse(0, 1, 0);
        check("stop_busy", 32'(if0.busy), 32'd0);
        check("stop_idx", 32'(if0.note_idx), 32'd0);
        check("stop_done", 32'(if0.song_done), 32'd0);
        cyc(3);
        pulse(1, 1, 0);
        check("start_stop_busy", 32'(if0.busy), 32'd0);
        cyc(3);

        repeat (4000) begin
            start = ($urandom_range(0, 199) == 0);
            stop  = ($urandom_range(0, 999) == 0);
            ptgl  = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        start = 1'b0; stop = 1'b0; ptgl = 1'b0;
        pulse(0, 1, 0);
        cyc(2);

        // Asynchronous reset in the middle of a note.
        pulse(1, 0, 0);
        cyc(50);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst0", {if0.period, if0.tone_en, if0.amp_sd, if0.busy, if0.note_idx, if0.song_done}, 32'd0);
        check("async_rst1", {if1.period, if1.tone_en, if1.amp_sd, if1.busy, if1.note_idx, if1.song_done}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
